// File: rtl/sram_bus_arbiter.sv
// Shares one sram-like port between instruction fetch and data access, one transaction outstanding.
// Define ARB_ROUND_ROBIN_EN to alternate grants on ties; otherwise data has fixed priority over inst.
module sram_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stallreq
);

  localparam int SW = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t              r_state;
  logic                r_owner;
  logic                r_wr;
  logic [SW-1:0]       r_wstrb;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                w_grant_data;
  logic                w_addr_ok;
  logic                w_data_ok;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_owner;
  // On a tie the side that did not win last time gets the port.
  always_comb begin
    w_grant_data = data_req & (~inst_req | ~r_last_owner);
  end
`else
  always_comb begin
    w_grant_data = data_req;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_wr    <= 1'b0;
      r_wstrb <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_owner <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (inst_req | data_req) begin
            r_owner <= w_grant_data;
            r_wr    <= w_grant_data & (|data_wen);
            r_wstrb <= w_grant_data ? data_wen   : '0;
            r_addr  <= w_grant_data ? data_addr  : inst_addr;
            r_wdata <= w_grant_data ? data_wdata : '0;
            r_state <= S_ADDR;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_owner <= w_grant_data;
`endif
          end
        end
        // A data_ok coinciding with addr_ok here is not a response to this request.
        S_ADDR:  if (mem_addr_ok) r_state <= S_DATA;
        S_DATA:  if (mem_data_ok) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_addr_ok    = (r_state == S_ADDR) & mem_addr_ok;
    w_data_ok    = (r_state == S_DATA) & mem_data_ok;
    inst_addr_ok = w_addr_ok & ~r_owner;
    data_addr_ok = w_addr_ok &  r_owner;
    inst_data_ok = w_data_ok & ~r_owner;
    data_data_ok = w_data_ok &  r_owner;
    inst_rdata   = inst_data_ok ? mem_rdata : '0;
    data_rdata   = data_data_ok ? mem_rdata : '0;
    mem_req      = (r_state == S_ADDR);
    mem_wr       = r_wr;
    mem_wstrb    = r_wstrb;
    mem_addr     = r_addr;
    mem_wdata    = r_wdata;
    stallreq     = (r_state != S_IDLE) | inst_req | data_req;
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed literal scenarios, then random masters and memory
// checked every cycle against a transaction-level model of the arbiter.
module tb_sram_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          inst_req = 1'b0;
  logic [AW-1:0] inst_addr = '0;
  logic          inst_addr_ok, inst_data_ok;
  logic [DW-1:0] inst_rdata;
  logic          data_req = 1'b0;
  logic [SW-1:0] data_wen = '0;
  logic [AW-1:0] data_addr = '0;
  logic [DW-1:0] data_wdata = '0;
  logic          data_addr_ok, data_data_ok;
  logic [DW-1:0] data_rdata;
  logic          mem_req, mem_wr;
  logic [SW-1:0] mem_wstrb;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_addr_ok = 1'b0;
  logic          mem_data_ok = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          stallreq;

  int total = 0;
  int bad   = 0;

  sram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .stallreq(stallreq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    bit            own;   // 1 = data requester
    bit            wr;
    logic [SW-1:0] strb;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  txn_t m_t;
  bit   m_busy = 1'b0;   // a granted transaction exists
  bit   m_acc  = 1'b0;   // its address has been accepted
  bit   m_last = 1'b1;   // side that received the most recent grant

  function automatic bit pick_data(input bit i, input bit d, input bit last);
`ifdef ARB_ROUND_ROBIN_EN
    if (i && d) return !last;
`endif
    return d;
  endfunction

  logic e_pick, e_mem_req, e_inst_aok, e_data_aok, e_inst_dok, e_data_dok, e_stall;
  assign e_pick     = pick_data(inst_req, data_req, m_last);
  assign e_mem_req  = m_busy && !m_acc;
  assign e_inst_aok = e_mem_req && !m_t.own && mem_addr_ok;
  assign e_data_aok = e_mem_req &&  m_t.own && mem_addr_ok;
  assign e_inst_dok = m_busy && m_acc && !m_t.own && mem_data_ok;
  assign e_data_dok = m_busy && m_acc &&  m_t.own && mem_data_ok;
  assign e_stall    = m_busy || inst_req || data_req;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_acc  <= 1'b0;
      m_last <= 1'b1;
    end else if (!m_busy) begin
      if (inst_req || data_req) begin
        m_t.own   <= e_pick;
        m_t.wr    <= e_pick && (data_wen != '0);
        m_t.strb  <= e_pick ? data_wen : '0;
        m_t.addr  <= e_pick ? data_addr : inst_addr;
        m_t.wdata <= e_pick ? data_wdata : '0;
        m_last    <= e_pick;
        m_busy    <= 1'b1;
        m_acc     <= 1'b0;
      end
    end else if (!m_acc) begin
      if (mem_addr_ok) m_acc <= 1'b1;
    end else if (mem_data_ok) begin
      m_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("mem_req", 32'(mem_req), 32'(e_mem_req));
    if (e_mem_req) begin
      chk("mem_wr", 32'(mem_wr), 32'(m_t.wr));
      chk("mem_wstrb", 32'(mem_wstrb), 32'(m_t.strb));
      chk("mem_addr", mem_addr, m_t.addr);
      chk("mem_wdata", mem_wdata, m_t.wdata);
    end
    chk("inst_addr_ok", 32'(inst_addr_ok), 32'(e_inst_aok));
    chk("data_addr_ok", 32'(data_addr_ok), 32'(e_data_aok));
    chk("inst_data_ok", 32'(inst_data_ok), 32'(e_inst_dok));
    chk("data_data_ok", 32'(data_data_ok), 32'(e_data_dok));
    chk("inst_rdata", inst_rdata, e_inst_dok ? mem_rdata : 32'h0);
    chk("data_rdata", data_rdata, e_data_dok ? mem_rdata : 32'h0);
    chk("stallreq", 32'(stallreq), 32'(e_stall));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    inst_req = 1'b0; data_req = 1'b0; data_wen = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
  endtask

  task automatic pulse_rst();
    rst = 1'b0;
    clr();
    tick();
    rst = 1'b1;
  endtask

  int pulses, stray;
  logic [AW-1:0] a0;
  bit ipend, dpend, ia, da;

  initial begin
    // reset state
    @(negedge clk);
    chk("rst mem_req", 32'(mem_req), 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wr", 32'(mem_wr), 32'h0);
    chk("rst oks", 32'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 32'h0);
    chk("rst stallreq", 32'(stallreq), 32'h0);
    tick();
    rst = 1'b1;

    // single zero-wait fetch
    tick();
    inst_req = 1'b1; inst_addr = 32'hBFC00000;
    @(negedge clk);
    chk("fetch c0 mem_req", 32'(mem_req), 32'h0);
    chk("fetch c0 stall", 32'(stallreq), 32'h1);
    tick();
    mem_addr_ok = 1'b1;
    @(negedge clk);
    chk("fetch c1 mem_req", 32'(mem_req), 32'h1);
    chk("fetch c1 mem_addr", mem_addr, 32'hBFC00000);
    chk("fetch c1 mem_wr", 32'(mem_wr), 32'h0);
    chk("fetch c1 inst_addr_ok", 32'(inst_addr_ok), 32'h1);
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h3C08BFC0;
    @(negedge clk);
    chk("fetch c2 inst_data_ok", 32'(inst_data_ok), 32'h1);
    chk("fetch c2 inst_rdata", inst_rdata, 32'h3C08BFC0);
    chk("fetch c2 data_data_ok", 32'(data_data_ok), 32'h0);
    tick();
    clr();
    @(negedge clk);
    chk("fetch c3 stall", 32'(stallreq), 32'h0);
    chk("fetch c3 inst_rdata", inst_rdata, 32'h0);

    // store with partial strobes
    pulses = 0; stray = 0;
    tick();
    data_req = 1'b1; data_wen = 4'b0011; data_addr = 32'h80001004; data_wdata = 32'hDEADBEEF;
    @(negedge clk);
    pulses += int'(data_data_ok);
    tick();
    mem_addr_ok = 1'b1;
    @(negedge clk);
    chk("store mem_wr", 32'(mem_wr), 32'h1);
    chk("store mem_wstrb", 32'(mem_wstrb), 32'h3);
    chk("store mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("store mem_addr", mem_addr, 32'h80001004);
    pulses += int'(data_data_ok);
    stray += int'(inst_addr_ok | inst_data_ok | (inst_rdata != 0));
    for (int k = 0; k < 4; k++) begin
      tick();
      clr();
      mem_data_ok = (k == 0); mem_rdata = 32'hA5A5A5A5;
      @(negedge clk);
      if (k == 0) chk("store data_rdata", data_rdata, 32'hA5A5A5A5);
      pulses += int'(data_data_ok);
      stray += int'(inst_addr_ok | inst_data_ok | (inst_rdata != 0));
    end
    chk("store data_ok pulses", 32'(pulses), 32'h1);
    chk("store inst quiet", 32'(stray), 32'h0);

    tick();
    pulse_rst();
`ifdef ARB_ROUND_ROBIN_EN
    // three back-to-back ties, both requesters held high
    inst_req = 1'b1; inst_addr = 32'hBFC00010;
    data_req = 1'b1; data_wen = '0; data_addr = 32'h80000020;
    for (int k = 0; k < 3; k++) begin
      tick();
      mem_addr_ok = 1'b1;
      @(negedge clk);
      chk("rr grant addr", mem_addr, (k == 1) ? 32'h80000020 : 32'hBFC00010);
      chk("rr grant owner", 32'(data_addr_ok), (k == 1) ? 32'h1 : 32'h0);
      tick();
      mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
      @(negedge clk);
      chk("rr data_ok", 32'({inst_data_ok, data_data_ok}), (k == 1) ? 32'h1 : 32'h2);
      tick();
      mem_data_ok = 1'b0;
      @(negedge clk);
      chk("rr bubble mem_req", 32'(mem_req), 32'h0);
    end
`else
    // tie: data first, inst after data_ok plus one idle cycle
    inst_req = 1'b1; inst_addr = 32'hBFC00010;
    data_req = 1'b1; data_wen = '0; data_addr = 32'h80000020;
    @(negedge clk);
    chk("tie c0 stall", 32'(stallreq), 32'h1);
    tick();
    mem_addr_ok = 1'b1;
    @(negedge clk);
    chk("tie c1 mem_addr", mem_addr, 32'h80000020);
    chk("tie c1 data_addr_ok", 32'(data_addr_ok), 32'h1);
    chk("tie c1 inst_addr_ok", 32'(inst_addr_ok), 32'h0);
    tick();
    data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    @(negedge clk);
    chk("tie c2 data_data_ok", 32'(data_data_ok), 32'h1);
    chk("tie c2 stall", 32'(stallreq), 32'h1);
    tick();
    mem_data_ok = 1'b0;
    @(negedge clk);
    chk("tie c3 bubble", 32'(mem_req), 32'h0);
    chk("tie c3 stall", 32'(stallreq), 32'h1);
    tick();
    mem_addr_ok = 1'b1;
    @(negedge clk);
    chk("tie c4 mem_addr", mem_addr, 32'hBFC00010);
    chk("tie c4 inst_addr_ok", 32'(inst_addr_ok), 32'h1);
    chk("tie c4 stall", 32'(stallreq), 32'h1);
`endif
    tick();
    pulse_rst();

    // address wait states
    pulses = 0;
    data_req = 1'b1; data_wen = 4'b1100; data_addr = 32'h80002008; data_wdata = 32'hCAFEF00D;
    @(negedge clk);
    pulses += int'(data_addr_ok | inst_addr_ok);
    for (int k = 0; k < 4; k++) begin
      tick();
      mem_addr_ok = (k == 3);
      @(negedge clk);
      chk("wait mem_req", 32'(mem_req), 32'h1);
      chk("wait mem_addr", mem_addr, 32'h80002008);
      chk("wait mem_wdata", mem_wdata, 32'hCAFEF00D);
      chk("wait mem_wstrb", 32'(mem_wstrb), 32'hC);
      pulses += int'(data_addr_ok | inst_addr_ok);
    end
    tick();
    data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    @(negedge clk);
    pulses += int'(data_addr_ok | inst_addr_ok);
    tick();
    clr();
    @(negedge clk);
    pulses += int'(data_addr_ok | inst_addr_ok);
    chk("wait addr_ok pulses", 32'(pulses), 32'h1);

    // reset while waiting for data; straggling response must be dropped
    tick();
    inst_req = 1'b1; inst_addr = 32'hBFC00000;
    tick();
    mem_addr_ok = 1'b1;
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("rstmid mem_req", 32'(mem_req), 32'h0);
    chk("rstmid stall", 32'(stallreq), 32'h0);
    tick();
    rst = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    chk("rstmid inst_data_ok", 32'(inst_data_ok), 32'h0);
    chk("rstmid inst_rdata", inst_rdata, 32'h0);
    chk("rstmid mem_req2", 32'(mem_req), 32'h0);
    chk("rstmid stall2", 32'(stallreq), 32'h0);
    tick();
    clr();

    // random masters and memory, checked by the model every cycle
    ipend = 1'b0; dpend = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      ia = e_inst_aok; da = e_data_aok;
      tick();
      if (ia) ipend = 1'b0;
      if (da) dpend = 1'b0;
      if (ipend && $urandom_range(0, 40) == 0) ipend = 1'b0;
      if (dpend && $urandom_range(0, 40) == 0) dpend = 1'b0;
      if (!ipend && $urandom_range(0, 3) == 0) begin
        ipend = 1'b1; inst_addr = $urandom;
      end
      if (!dpend && $urandom_range(0, 3) == 0) begin
        dpend = 1'b1; data_addr = $urandom; data_wdata = $urandom;
        data_wen = ($urandom_range(0, 1) == 1) ? SW'($urandom) : '0;
      end
      inst_req = ipend;
      data_req = dpend;
      mem_addr_ok = e_mem_req && ($urandom_range(0, 2) == 0);
      mem_data_ok = (m_busy && m_acc) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;
    end
    tick();
    clr();
    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    a0 = '0;
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one sram-like memory port between the instruction-fetch requester (IF/ID side) and the data requester (EX/MEM side) of the 5-stage core.
- Keeps at most one transaction outstanding, latches the winning request, sequences the address and data handshakes, and routes the response back to its owner.
- Drives a stall request into CTRL while any access is pending.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports; byte-strobe width is DATA_W/8

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; asynchronous, active-low
- inst_req  in  1  fetch request; held until inst_addr_ok
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  fetch address accepted
- inst_data_ok  out  1  fetch data valid
- inst_rdata  out  DATA_W  fetch data
- data_req  in  1  load/store request; held until data_addr_ok
- data_wen  in  DATA_W/8  byte write enables; 0 means read
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  store data
- data_addr_ok  out  1  data address accepted
- data_data_ok  out  1  load data valid / store complete
- data_rdata  out  DATA_W  load data
- mem_req  out  1  unified port request
- mem_wr  out  1  1 = write
- mem_wstrb  out  DATA_W/8  byte strobes
- mem_addr  out  ADDR_W  address
- mem_wdata  out  DATA_W  write data
- mem_addr_ok  in  1  memory accepted address
- mem_data_ok  in  1  memory response valid
- mem_rdata  in  DATA_W  memory read data
- stallreq  out  1  pipeline stall request to CTRL

Behaviour:
- States: IDLE, ADDR, DATA. Internal registers: owner (0 = inst, 1 = data), and latched wr, wstrb, addr, wdata.
- Reset (rst=0, asynchronous):
  - state=IDLE, owner=0, all latched fields 0.
  - mem_req=0, so all *_ok outputs read 0.
- IDLE:
  - If inst_req or data_req, pick a winner and latch its fields. mem_wr = (wen != 0); inst is always a read with wstrb 0.
  - Set owner and go to ADDR.
  - mem_data_ok arriving in IDLE is ignored; a response straggling after a reset is dropped.
- ADDR:
  - mem_req=1 and mem_* are driven from the latched registers, stable until accepted.
  - On mem_addr_ok=1: the owner's X_addr_ok=1 combinationally in that same cycle. Go to DATA.
- DATA:
  - mem_req=0.
  - On mem_data_ok=1: the owner's X_data_ok=1 and X_rdata=mem_rdata combinationally. Go to IDLE.
  - Writes also complete through mem_data_ok.
- Latency: request seen in IDLE cycle N gives mem_req high in cycle N+1. Earliest completion is N+2 if memory is ready with zero wait.
- Bubble: one mandatory IDLE cycle between transactions.
- Non-owner outputs: *_ok are always 0. X_rdata is 0 whenever X_data_ok=0.
- Arbitration (default, fixed priority): data wins over inst when both request in IDLE. A losing request keeps waiting.
- A requester that drops req before its addr_ok is not protected: the latched copy is still issued and its response is still delivered.
- stallreq = (state != IDLE) | inst_req | data_req, combinational. It falls in the cycle after the last data_ok if there are no new requests.
- Simultaneous mem_addr_ok and mem_data_ok in ADDR: only the addr_ok is consumed. The data_ok is not valid before the address phase completes.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - A last_owner register exists, reset to 1 (data).
  - On a tie in IDLE, the requester that is not last_owner wins.
  - last_owner updates when a grant is made.
  - A single requester always wins.
- Undefined: fixed data-over-inst priority and no last_owner register.

Test Plan:
- Reset mid-transaction:
  - Stimulus: inst_req=1, addr 0xBFC00000, mem_addr_ok=1 in cycle 2; assert rst=0 in the DATA state; then mem_data_ok=1 with rdata 0x12345678.
  - Required: state returns to IDLE; inst_data_ok stays 0; mem_req=0.
- Single fetch:
  - Stimulus: inst_req=1, addr 0xBFC00000, memory zero-wait.
  - Required: mem_req=1 in cycle 1 with mem_addr=0xBFC00000 and mem_wr=0; inst_addr_ok=1 in cycle 1.
  - Required: mem_data_ok with rdata 0x3C08BFC0 gives inst_data_ok=1 and inst_rdata=0x3C08BFC0 in cycle 2.
- Store:
  - Stimulus: data_req=1, wen=4'b0011, addr 0x80001004, wdata 0xDEADBEEF.
  - Required: mem_wr=1, mem_wstrb=0011, mem_wdata=0xDEADBEEF; data_data_ok pulses once; inst_* outputs stay 0.
- Tie, fixed priority:
  - Stimulus: inst_req and data_req both rise in the same cycle.
  - Required: the data access is issued first; inst is issued after data_data_ok plus one IDLE cycle; stallreq stays 1 throughout.
- Tie, ARB_ROUND_ROBIN_EN defined:
  - Stimulus: three back-to-back ties.
  - Required: grants go inst, data, inst.
- Wait states:
  - Stimulus: mem_addr_ok is held 0 for 3 cycles.
  - Required: mem_addr, mem_wdata and mem_wstrb stay constant and mem_req stays 1 until acceptance; exactly one X_addr_ok pulse is produced.
